// File: rtl/inexrecur_fetch.sv
// -----------------------------------------------------------------------------
// inexrecur_fetch
//
// Drains the inexact-recursion register file in order through its
// sequential-read port. Each word is unpacked into {i,z,k,l}. When FILTER_EMPTY
// is set, words describing an empty SA interval (k > l) are dropped. Surviving
// tuples are offered to the recursion compute stage over valid/ready.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, abort      one-cycle control pulses (abort has priority)
//   entry_cnt         number of entries to drain, sampled on accepted start
//   seq_re            sequential-read strobe, one cycle per entry
//   r_addr, r_data    register-file address/word, valid while seq_re=1
//   out_valid/ready   output handshake
//   out_i/z/k/l       unpacked fields, out_addr source address
//   out_last          tuple came from the final entry
//   busy, done        run status; done is a one-cycle pulse
//   drop_cnt          entries dropped by the filter in the current/last run
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | reading entries; one seq_re per free output slot
// DRAIN  | all entries read, waiting for the last tuple to be consumed
// DONE   | single-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module inexrecur_fetch #(
    parameter int ADDR_W       = 12,
    parameter int FIELD_W      = 8,
    parameter int FILTER_EMPTY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W:0]      entry_cnt,
    output logic                 seq_re,
    input  logic [ADDR_W-1:0]    r_addr,
    input  logic [4*FIELD_W-1:0] r_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FIELD_W-1:0]   out_i,
    output logic [FIELD_W-1:0]   out_z,
    output logic [FIELD_W-1:0]   out_k,
    output logic [FIELD_W-1:0]   out_l,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      drop_cnt
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(1) << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   remain;
    logic [CNT_W-1:0]   cnt_clamped;
    logic               take_start;
    logic               slot_free;
    logic               consumed;
    logic [FIELD_W-1:0] w_i;
    logic [FIELD_W-1:0] w_z;
    logic [FIELD_W-1:0] w_k;
    logic [FIELD_W-1:0] w_l;
    logic               drop_word;

    assign w_i = r_data[4*FIELD_W-1 -: FIELD_W];
    assign w_z = r_data[3*FIELD_W-1 -: FIELD_W];
    assign w_k = r_data[2*FIELD_W-1 -: FIELD_W];
    assign w_l = r_data[FIELD_W-1   -: FIELD_W];

    assign drop_word   = (FILTER_EMPTY != 0) && (w_k > w_l);
    assign consumed    = out_valid && out_ready;
    // The output register can accept a new word if it is empty or being
    // emptied by a handshake on this same edge.
    assign slot_free   = !out_valid || out_ready;
    assign cnt_clamped = (entry_cnt > MAX_CNT) ? MAX_CNT : entry_cnt;

    assign busy = (state == S_FETCH) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_comb begin
        state_nx   = state;
        seq_re     = 1'b0;
        take_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    state_nx   = (entry_cnt == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (slot_free) begin
                    seq_re = 1'b1;
                    if (remain == CNT_W'(1)) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (slot_free) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Gating seq_re here keeps the file pointer from advancing on a word
        // that would never be captured.
        if (abort) begin
            state_nx   = S_IDLE;
            seq_re     = 1'b0;
            take_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remain    <= '0;
            drop_cnt  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_i     <= '0;
            out_z     <= '0;
            out_k     <= '0;
            out_l     <= '0;
            out_addr  <= '0;
        end else begin
            state <= state_nx;

            if (take_start) begin
                remain   <= cnt_clamped;
                drop_cnt <= '0;
            end else if (seq_re) begin
                remain <= remain - CNT_W'(1);
                if (drop_word) drop_cnt <= drop_cnt + CNT_W'(1);
            end

            if (abort) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (seq_re && !drop_word) begin
                out_valid <= 1'b1;
                out_last  <= (remain == CNT_W'(1));
                out_i     <= w_i;
                out_z     <= w_z;
                out_k     <= w_k;
                out_l     <= w_l;
                out_addr  <= r_addr;
            end else if (seq_re || consumed) begin
                // Dropped word or plain handshake: the slot ends up empty.
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inexrecur_fetch.sv
// -----------------------------------------------------------------------------
// tb_inexrecur_fetch
//
// Directed bench for inexrecur_fetch. A small register-file model serves words
// from mem[] and advances its pointer on each seq_re edge. A negedge monitor
// logs seq_re cycles, accepted tuples and done pulses; the directed sequences
// compare those logs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_inexrecur_fetch;

    localparam int ADDR_W  = 12;
    localparam int FIELD_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic [ADDR_W:0]   entry_cnt = '0;
    logic              seq_re;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              out_valid;
    logic [7:0]        out_i, out_z, out_k, out_l;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   drop_cnt;

    inexrecur_fetch #(.ADDR_W(ADDR_W), .FIELD_W(FIELD_W), .FILTER_EMPTY(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .entry_cnt(entry_cnt), .seq_re(seq_re), .r_addr(r_addr), .r_data(r_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_z(out_z), .out_k(out_k), .out_l(out_l),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // register-file model
    logic [31:0]       mem [0:15];
    logic [ADDR_W-1:0] ptr = '0;
    logic [ADDR_W-1:0] base = '0;
    assign r_addr = ptr - base;
    assign r_data = mem[r_addr[3:0]];
    always @(posedge clk) if (seq_re) ptr <= ptr + 1'b1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor
    logic [63:0] tlog [0:255];
    int          seq_cyc [0:255];
    int          log_n = 0;
    int          seq_n = 0;
    int          done_n = 0;
    int          done_cyc = 0;
    always @(negedge clk) begin
        if (seq_re) begin
            seq_cyc[seq_n & 255] = cyc;
            seq_n++;
        end
        if (out_valid && out_ready) begin
            tlog[log_n & 255] = {19'd0, out_last, out_addr, out_i, out_z, out_k, out_l};
            log_n++;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W:0] n);
        start     = 1'b1;
        entry_cnt = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_n;
        int k  = 0;
        while (done_n == d0 && k < 60) begin
            tick();
            k++;
        end
        chk({tag, " done seen"}, 64'(done_n != d0), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!out_valid && k < 30) begin
            tick();
            k++;
        end
        chk({tag, " valid seen"}, 64'(out_valid), 64'd1);
    endtask

    task automatic chk_tup(input string tag, input int idx, input logic last,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] word);
        chk(tag, tlog[idx & 255], {19'd0, last, addr, word});
    endtask

    task automatic load_abc();
        mem[0] = 32'h0102_0304;
        mem[1] = 32'h0506_0708;
        mem[2] = 32'h090A_0B0C;
    endtask

    int s0, l0, d0;
    logic [31:0] held;

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 0);
        chk("rst busy", 64'(busy), 0);
        chk("rst done", 64'(done), 0);
        chk("rst seq_re", 64'(seq_re), 0);
        chk("rst drop_cnt", 64'(drop_cnt), 0);
        rst_n = 1'b1;
        tick();

        // 1: three entries, free-flowing
        load_abc();
        base = ptr; out_ready = 1'b1; s0 = seq_n; l0 = log_n;
        pulse_start(3);
        wait_done("t1");
        chk("t1 seq count", 64'(seq_n - s0), 3);
        chk("t1 consecutive", 64'(seq_cyc[(s0 + 2) & 255] - seq_cyc[s0 & 255]), 2);
        chk("t1 done latency", 64'(done_cyc - seq_cyc[(s0 + 2) & 255]), 2);
        chk("t1 ntup", 64'(log_n - l0), 3);
        chk_tup("t1 tup0", l0,     1'b0, 12'd0, 32'h0102_0304);
        chk_tup("t1 tup1", l0 + 1, 1'b0, 12'd1, 32'h0506_0708);
        chk_tup("t1 tup2", l0 + 2, 1'b1, 12'd2, 32'h090A_0B0C);
        chk("t1 drop_cnt", 64'(drop_cnt), 0);

        // 2: stall on the first tuple for 5 cycles
        tick();
        base = ptr; out_ready = 1'b0; s0 = seq_n; l0 = log_n;
        pulse_start(3);
        wait_valid("t2");
        held = {out_i, out_z, out_k, out_l};
        chk("t2 first word", 64'(held), 64'h0102_0304);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2 hold", {31'd0, out_valid, out_i, out_z, out_k, out_l}, {31'd0, 1'b1, held});
            chk("t2 seq_re stall", 64'(seq_re), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("t2");
        chk("t2 seq count", 64'(seq_n - s0), 3);
        chk("t2 ntup", 64'(log_n - l0), 3);
        chk_tup("t2 tup0", l0,     1'b0, 12'd0, 32'h0102_0304);
        chk_tup("t2 tup1", l0 + 1, 1'b0, 12'd1, 32'h0506_0708);
        chk_tup("t2 tup2", l0 + 2, 1'b1, 12'd2, 32'h090A_0B0C);

        // 3: empty interval filtered
        tick();
        mem[0] = 32'h0000_0A05;
        mem[1] = 32'h0000_0307;
        base = ptr; out_ready = 1'b1; s0 = seq_n; l0 = log_n;
        pulse_start(2);
        wait_done("t3");
        chk("t3 seq count", 64'(seq_n - s0), 2);
        chk("t3 ntup", 64'(log_n - l0), 1);
        chk_tup("t3 tup", l0, 1'b1, 12'd1, 32'h0000_0307);
        chk("t3 drop_cnt", 64'(drop_cnt), 1);

        // 4: zero entries
        tick();
        s0 = seq_n; l0 = log_n; d0 = done_n;
        pulse_start(0);
        @(negedge clk);
        chk("t4 done", 64'(done), 1);
        chk("t4 out_valid", 64'(out_valid), 0);
        @(posedge clk); #1;
        repeat (3) tick();
        chk("t4 seq count", 64'(seq_n - s0), 0);
        chk("t4 ntup", 64'(log_n - l0), 0);
        chk("t4 done count", 64'(done_n - d0), 1);

        // 5: abort with a tuple held, then restart
        load_abc();
        base = ptr; out_ready = 1'b0;
        pulse_start(3);
        wait_valid("t5");
        d0 = done_n;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5 out_valid", 64'(out_valid), 0);
        chk("t5 busy", 64'(busy), 0);
        chk("t5 seq_re", 64'(seq_re), 0);
        repeat (4) tick();
        chk("t5 no done", 64'(done_n - d0), 0);
        base = ptr; out_ready = 1'b1; s0 = seq_n; l0 = log_n;
        pulse_start(3);
        wait_done("t5 restart");
        chk("t5 ntup", 64'(log_n - l0), 3);
        chk_tup("t5 tup0", l0, 1'b0, 12'd0, 32'h0102_0304);
        chk_tup("t5 tup2", l0 + 2, 1'b1, 12'd2, 32'h090A_0B0C);

        // 6a: start while busy is ignored
        tick();
        base = ptr; out_ready = 1'b0; s0 = seq_n; l0 = log_n;
        pulse_start(3);
        wait_valid("t6a");
        pulse_start(5);
        chk("t6a busy", 64'(busy), 1);
        out_ready = 1'b1;
        wait_done("t6a");
        chk("t6a seq count", 64'(seq_n - s0), 3);
        chk("t6a ntup", 64'(log_n - l0), 3);
        chk_tup("t6a tup2", l0 + 2, 1'b1, 12'd2, 32'h090A_0B0C);

        // 6b: asynchronous reset mid-run
        tick();
        mem[0] = 32'h0000_0A05;
        mem[1] = 32'h0000_0307;
        mem[2] = 32'h0102_0304;
        base = ptr; out_ready = 1'b0;
        pulse_start(3);
        wait_valid("t6b");
        chk("t6b drop pre", 64'(drop_cnt), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6b out_valid", 64'(out_valid), 0);
        chk("t6b busy", 64'(busy), 0);
        chk("t6b seq_re", 64'(seq_re), 0);
        chk("t6b drop_cnt", 64'(drop_cnt), 0);
        chk("t6b fields", {31'd0, out_last, out_i, out_z, out_k, out_l}, 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
